// File: rtl/line_data_memory.sv
// -----------------------------------------------------------------------------
// line_data_memory
//
// Line-granular main-memory model that answers the data cache's miss and
// write-back requests. One 256-bit line read or write is accepted at a time,
// held for a fixed access latency, then completed with a one-cycle ack pulse.
//
// Parameters
//   LATENCY      cycles from request acceptance to ack_o (1..255)
//   LINE_ADDR_W  line-index width; depth is 2**LINE_ADDR_W lines of 256 bits
//
// Ports
//   clk_i     in   1    clock, rising edge
//   rst_i     in   1    asynchronous, active-low reset
//   enable_i  in   1    request valid, held by the cache until ack_o
//   write_i   in   1    1 = line write, 0 = line read (sampled at acceptance)
//   addr_i    in   32   byte address; line index is addr_i[LINE_ADDR_W+4:5]
//   data_i    in   256  write line (sampled at acceptance)
//   ack_o     out  1    registered one-cycle completion pulse
//   data_o    out  256  read line, valid from the ack_o cycle of a read
// -----------------------------------------------------------------------------
module line_data_memory #(
    parameter int LATENCY     = 10,
    parameter int LINE_ADDR_W = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o
);

    localparam int DEPTH = 1 << LINE_ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    // The counter runs LATENCY-1 down to 0, so completion lands exactly
    // LATENCY edges after the accepting edge.
    localparam logic [7:0] COUNT_LOAD = 8'(LATENCY - 1);

    // Storage is deliberately not reset; the bench loads it.
    logic [255:0] mem [DEPTH];

    logic [1:0]             state_q;
    logic [7:0]             count_q;
    logic [LINE_ADDR_W-1:0] idx_q;
    logic                   wr_q;
    logic [255:0]           wdata_q;

    logic [LINE_ADDR_W-1:0] req_idx;
    logic                   done;
    logic                   unused_addr;

    // Byte offset and bits above the line index are don't-care; taking the
    // slice gives the modulo-depth wrap for free.
    assign req_idx     = addr_i[LINE_ADDR_W+4:5];
    assign unused_addr = ^addr_i;

    assign done = (state_q == ST_WAIT) && (count_q == 8'd0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            count_q <= 8'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            ack_o   <= 1'b0;
            data_o  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_o <= 1'b0;
                    if (enable_i) begin
                        idx_q   <= req_idx;
                        wr_q    <= write_i;
                        wdata_q <= data_i;
                        count_q <= COUNT_LOAD;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (count_q == 8'd0) begin
                        if (!wr_q) begin
                            data_o <= mem[idx_q];
                        end
                        ack_o   <= 1'b1;
                        state_q <= ST_ACK;
                    end else begin
                        count_q <= count_q - 8'd1;
                    end
                end
                ST_ACK: begin
                    // enable_i is ignored here, which forces the idle cycle
                    // between an ack and the next acceptance.
                    ack_o   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ack_o   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Array write port. A reset during WAIT forces state_q to IDLE at once,
    // so an aborted write never reaches the array.
    always_ff @(posedge clk_i) begin
        if (done && wr_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_line_data_memory.sv
// -----------------------------------------------------------------------------
// tb_line_data_memory
//
// Self-checking bench for line_data_memory. A flat array model holds the
// expected memory contents; requests are issued through the cache-side
// interface and every ack, latency and read value is compared with the model.
// -----------------------------------------------------------------------------
module tb_line_data_memory;

    localparam int LATENCY     = 10;
    localparam int LINE_ADDR_W = 9;
    localparam int DEPTH       = 1 << LINE_ADDR_W;

    logic         clk_i;
    logic         rst_i;
    logic         enable_i;
    logic         write_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         ack_o;
    logic [255:0] data_o;

    line_data_memory #(
        .LATENCY     (LATENCY),
        .LINE_ADDR_W (LINE_ADDR_W)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .ack_o    (ack_o),
        .data_o   (data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: plain array of lines plus the last value read out.
    logic [255:0] model_mem [DEPTH];
    logic [255:0] model_data_o;

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int lineOf(input logic [31:0] a);
        return int'((a / 32) % DEPTH);
    endfunction

    task automatic stepCycle();
        @(posedge clk_i);
        #1;
    endtask

    // Steps up to limit edges looking for ack_o; cycles = edges taken, or -1.
    task automatic waitAck(input int limit, input int drop_after,
                           input bit scramble, output int cycles);
        cycles = -1;
        for (int k = 1; k <= limit; k++) begin
            if (k == drop_after) enable_i = 1'b0;
            if (scramble) begin
                addr_i  = $urandom;
                write_i = 1'($urandom);
                data_i  = rand256();
            end
            stepCycle();
            if (ack_o === 1'b1) begin
                cycles = k;
                break;
            end
        end
    endtask

    // Issues one request from idle, checks latency and data_o at the ack.
    // Unless keep_enable is set, drops enable and checks the ack is one cycle.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [255:0] data, input int drop_after,
                                 input bit scramble, input bit keep_enable,
                                 input string tag);
        int cycles;
        int idx;
        enable_i = 1'b1;
        write_i  = wr;
        addr_i   = addr;
        data_i   = data;
        stepCycle();
        idx = lineOf(addr);
        if (wr) model_mem[idx] = data;
        else    model_data_o   = model_mem[idx];
        waitAck(LATENCY + 6, drop_after, scramble, cycles);
        checkOutput({tag, " latency"}, 256'(cycles), 256'(LATENCY));
        checkOutput({tag, " data_o"}, data_o, model_data_o);
        if (!keep_enable) begin
            enable_i = 1'b0;
            stepCycle();
            checkOutput({tag, " ack width"}, 256'(ack_o), 256'(0));
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        logic [255:0] pattern;

        rst_i    = 1'b0;
        enable_i = 1'b0;
        write_i  = 1'b0;
        addr_i   = '0;
        data_i   = '0;
        model_data_o = '0;
        repeat (2) stepCycle();
        checkOutput("reset ack_o", 256'(ack_o), 256'(0));
        checkOutput("reset data_o", data_o, 256'(0));
        rst_i = 1'b1;
        stepCycle();

        // Load every line through the port with junk in the ignored bits.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, ($urandom & ~32'h3FE0) | (32'(i) << 5),
                          rand256(), 0, 1'b0, 1'b0, "preload");
        end

        // Read of line 3 with a known pattern.
        pattern = {rand256() >> 8, 8'hA5};
        applyStimulus(1'b1, 32'h0000_0060, pattern, 0, 1'b0, 1'b0, "line3 wr");
        applyStimulus(1'b0, 32'h0000_0060, '0, 0, 1'b0, 1'b0, "line3 rd");

        // Write then read back line 32.
        applyStimulus(1'b1, 32'h0000_0400, {8{32'hDEADBEEF}}, 0, 1'b0, 1'b0, "line32 wr");
        applyStimulus(1'b0, 32'h0000_0400, '0, 0, 1'b0, 1'b0, "line32 rd");

        // Write-back of line 5 followed immediately by refill of line 9.
        applyStimulus(1'b1, 32'h0000_00A0, rand256(), 0, 1'b0, 1'b1, "wb line5");
        write_i = 1'b0;
        addr_i  = 32'h0000_0120;
        model_data_o = model_mem[9];
        waitAck(LATENCY + 8, 0, 1'b0, cycles);
        checkOutput("refill ack spacing", 256'(cycles), 256'(LATENCY + 2));
        checkOutput("refill data_o", data_o, model_data_o);
        enable_i = 1'b0;
        stepCycle();
        checkOutput("refill ack width", 256'(ack_o), 256'(0));
        applyStimulus(1'b0, 32'h0000_00A0, '0, 0, 1'b0, 1'b0, "line5 rd");

        // Reset four cycles into a write of line 7.
        enable_i = 1'b1;
        write_i  = 1'b1;
        addr_i   = 32'h0000_00E0;
        data_i   = rand256();
        stepCycle();
        repeat (4) stepCycle();
        rst_i = 1'b0;
        #1;
        checkOutput("abort ack_o", 256'(ack_o), 256'(0));
        checkOutput("abort data_o", data_o, 256'(0));
        model_data_o = '0;
        enable_i = 1'b0;
        repeat (2) stepCycle();
        rst_i = 1'b1;
        waitAck(LATENCY + 6, 0, 1'b0, cycles);
        checkOutput("abort no ack", 256'(cycles), 256'(-1));
        applyStimulus(1'b0, 32'h0000_00E0, '0, 0, 1'b0, 1'b0, "line7 rd");

        // Wrap: bits [4:0] and above the index are ignored, so line 0.
        applyStimulus(1'b0, 32'h0000_401F, '0, 0, 1'b0, 1'b0, "wrap rd");

        // Enable dropped three cycles into a read of line 2.
        applyStimulus(1'b0, 32'h0000_0040, '0, 3, 1'b0, 1'b0, "drop rd");
        waitAck(LATENCY + 6, 0, 1'b0, cycles);
        checkOutput("drop no accept", 256'(cycles), 256'(-1));

        // Random traffic with inputs scrambled while each request is busy.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) stepCycle();
            applyStimulus(1'($urandom), $urandom, rand256(), 0, 1'b1, 1'b0, "random");
        end

        // Every line of the array against the model.
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput($sformatf("array line %0d", i), dut.mem[i], model_mem[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/line_data_memory.md
# line_data_memory

Line-granular main-memory model that answers the data cache's miss and write-back requests. It accepts one 256-bit line read or write at a time over the enable/write/address/data interface, waits a fixed access latency, then pulses `ack_o` for one cycle. It sits below the data cache in the CPU top level and is the responder for the cache's memory port.

## Interface
- `LATENCY`, 10: cycles from request acceptance to `ack_o`; legal range 1..255.
- `LINE_ADDR_W`, 9: line-index width; memory depth is 2^LINE_ADDR_W lines of 256 bits.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `enable_i`  in  1  request valid; the cache holds it until it sees `ack_o`.
- `write_i`  in  1  1 = line write, 0 = line read; sampled at acceptance.
- `addr_i`  in  32  byte address; line index = `addr_i[LINE_ADDR_W+4:5]`, bits [4:0] ignored, upper bits ignored.
- `data_i`  in  256  write line; sampled at acceptance.
- `ack_o`  out  1  one-cycle completion pulse.
- `data_o`  out  256  read line; valid from the `ack_o` cycle of a read.

## Operation
- State machine with three states:
  - IDLE: `enable_i`=1 at an edge accepts the request. The block latches the line index, `write_i` and `data_i`, loads the counter with LATENCY-1 and moves to WAIT. `enable_i`=0 keeps the block in IDLE.
  - WAIT: the counter decrements each edge. At the edge where counter==0:
    - write: the array line is written with the latched data.
    - read: `data_o` is loaded from the array line.
    - Then go to ACK.
  - ACK: `ack_o`=1 for this cycle only; unconditionally return to IDLE at the next edge. `enable_i` is ignored in ACK.
- Latched fields decouple the block from the inputs. Changes to `addr_i`, `write_i`, `data_i` or `enable_i` after acceptance have no effect; a request whose `enable_i` drops mid-WAIT still completes and acks.
- Back-to-back requests: the cache's write-back leaves `enable_i` high with `write_i` switching to 0 after the ack. The first edge in IDLE accepts that follow-on read. There is one idle cycle between `ack_o` and the next acceptance.
- `data_o` changes only on read completion and holds its value across writes and idle periods.
- Address wrap: line index is taken modulo 2^LINE_ADDR_W, so there are no out-of-range errors.
- The array is not cleared by reset; contents are preloaded by the bench.

## Timing
- Reset values: state IDLE, `ack_o`=0, `data_o`=0, counter=0. Reset is asynchronous, so outputs drop immediately on `rst_i` falling.
- Reset during WAIT or ACK aborts the request: no array write, no ack. After release the block is in IDLE.
- Latency: request accepted at edge E0 gives `ack_o` high in the cycle following edge E0+LATENCY. For LATENCY=1, WAIT lasts exactly one cycle.
- Write visibility: a read accepted after a write's ack returns the written line.
- Throughput: one request per LATENCY+2 cycles at most.
- `ack_o` is registered, so there is no combinational path from inputs to outputs.

## Test plan
- Read: preload line 3 = 256'h…A5; request enable=1, write=0, addr=32'h0000_0060, hold until ack. Required: `ack_o` high exactly 10 cycles after acceptance, for 1 cycle; `data_o`=preloaded value.
- Write then read: write 256'hDEADBEEF… to addr 32'h0000_0400 (line 32); after the ack, read the same address. Required: read returns 256'hDEADBEEF…; every other line is unchanged.
- Cache-style write-back plus refill: write line 5, then keep enable high and drop `write_i` on the ack edge with addr changed to line 9. Required: two acks 12 cycles apart; line 5 updated; `data_o`=line 9 contents.
- Reset mid-WAIT: start a write to line 7 and assert `rst_i` low 4 cycles after acceptance. Required: `ack_o` stays 0; line 7 keeps its old value; `data_o`=0 after reset.
- Wrap and ignored bits: read addr 32'h0000_401F with LINE_ADDR_W=9. Required: returns line 0 (bits [4:0] and bits above [13] ignored).
- Enable dropped mid-WAIT: accept a read of line 2, then deassert enable after 3 cycles. Required: `ack_o` still pulses at latency 10 with line 2 data; no new request is accepted while enable is low.
